// File: rtl/sync_sram.sv
// Synchronous single-port SRAM with byte masks, registered read and a hardware clear sweep.
// Latency: read data and read_valid one cycle after the read edge; access_error one cycle after.
// Backpressure: none; while busy (clear sweep) every host access and clear_request is dropped.
//
// Ports:
//   clock, reset_n                   rising-edge clock, async active-low reset
//   address, write_data              word address and write data
//   byte_enable_n                    active-low lane mask, bit i covers data[8i+7:8i]
//   chip_enable, write_enable,       active-low select; 0 = write / 1 = read;
//   output_enable                    active-low output enable (must be 1 for writes)
//   clear_request                    pulse that starts a full INIT_VALUE sweep
//   read_data, read_valid            registered read word and its one-cycle strobe
//   busy, access_error               sweep in progress; illegal-access pulse
module sync_sram #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    RAM_DEPTH  = 256,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [ADDR_WIDTH-1:0]     address,
   input  logic [DATA_WIDTH-1:0]     write_data,
   input  logic [DATA_WIDTH/8-1:0]   byte_enable_n,
   input  logic                      chip_enable,
   input  logic                      write_enable,
   input  logic                      output_enable,
   input  logic                      clear_request,
   output logic [DATA_WIDTH-1:0]     read_data,
   output logic                      read_valid,
   output logic                      busy,
   output logic                      access_error
);

   localparam int BYTES = DATA_WIDTH / 8;
   // One extra bit so RAM_DEPTH == 2**ADDR_WIDTH is representable and never wraps.
   localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(RAM_DEPTH);
   localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH:0]   ptr, ptr_nxt;
   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   logic ready;
   logic sel;
   logic is_wr;
   logic is_rd;
   logic is_cont;
   logic in_range;

   assign ready    = (state == ST_READY);
   assign busy     = ~ready;
   assign in_range = ({1'b0, address} < DEPTH_W);

   // Host access decode; only meaningful outside the sweep.
   assign sel     = ready & ~chip_enable;
   assign is_wr   = sel & ~write_enable &  output_enable;
   assign is_rd   = sel &  write_enable & ~output_enable;
   assign is_cont = sel & ~write_enable & ~output_enable;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      case (state)
         ST_CLEAR: begin
            if (ptr == LAST_PTR) begin
               state_nxt = ST_READY;
               ptr_nxt   = '0;
            end else begin
               ptr_nxt = ptr + 1'b1;
            end
         end
         ST_READY: begin
            // Any access this cycle still completes; the sweep begins on the next edge.
            if (clear_request) begin
               state_nxt = ST_CLEAR;
               ptr_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_CLEAR;
            ptr_nxt   = '0;
         end
      endcase
   end

   // Storage is never reset; the sweep is what initialises it.
   always_ff @(posedge clock) begin
      if (state == ST_CLEAR) begin
         mem[ptr[ADDR_WIDTH-1:0]] <= INIT_VALUE;
      end else if (is_wr && in_range) begin
         for (int i = 0; i < BYTES; i++) begin
            if (!byte_enable_n[i]) begin
               mem[address][8*i +: 8] <= write_data[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         read_data    <= '0;
         read_valid   <= 1'b0;
         access_error <= 1'b0;
      end else begin
         read_valid   <= 1'b0;
         access_error <= 1'b0;
         if (is_cont) begin
            access_error <= 1'b1;
         end else if (is_wr && !in_range) begin
            access_error <= 1'b1;
         end else if (is_rd) begin
            read_valid <= 1'b1;
            if (in_range) begin
               read_data <= mem[address];
            end else begin
               // Out-of-range reads still strobe valid, with zero data.
               read_data    <= '0;
               access_error <= 1'b1;
            end
         end
      end
   end

endmodule
